// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit framer.
// Combinational only: no latency.
// No flow control of its own.
package udp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    HEADER,
    PAYLOAD,
    DROP
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam int          HDR_BYTES      = 42;
  localparam int          UDP_HDR_BYTES  = 8;

  // Descriptor latched at header acceptance; ttl already has the default applied.
  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] ident;
    logic [7:0]  ttl;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
  } udp_tx_hdr_t;

  // Ten 16-bit words sum to < 2^20, so two end-around-carry folds always settle.
  function automatic logic [15:0] csum_fold(input logic [31:0] s);
    logic [16:0] s1;
    logic [15:0] s2;
    s1 = {1'b0, s[15:0]} + {1'b0, s[31:16]};
    s2 = s1[15:0] + {15'b0, s1[16]};
    return ~s2;
  endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// IPv4 header checksum over the latched descriptor (checksum field taken as zero).
// Latency: sum registered on the start cycle; folded result valid the following cycle.
// No backpressure: start_i is a single-cycle pulse and the result is sampled on csum_vld_o.
module ip_hdr_csum
  import udp_tx_pkg::*;
#(
  parameter logic IP_DF = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  dscp_ecn_i,
  input  logic [15:0] ident_i,
  input  logic [7:0]  ttl_i,
  input  logic [15:0] udp_len_i,
  input  logic [31:0] src_ip_i,
  input  logic [31:0] dst_ip_i,
  output logic        csum_vld_o,
  output logic [15:0] csum_o
);

  logic [15:0] ip_len;
  logic [31:0] sum_d;
  logic [31:0] sum_q;
  logic        vld_q;

  assign ip_len = udp_len_i + 16'd20;

  // Stage 1: plain 32-bit sum of the ten header words.
  always_comb begin
    sum_d = {16'b0, IP_VER_IHL, dscp_ecn_i}
          + {16'b0, ip_len}
          + {16'b0, ident_i}
          + {16'b0, 1'b0, IP_DF, 14'b0}
          + {16'b0, ttl_i, IP_PROTO_UDP}
          + {16'b0, src_ip_i[31:16]}
          + {16'b0, src_ip_i[15:0]}
          + {16'b0, dst_ip_i[31:16]}
          + {16'b0, dst_ip_i[15:0]};
  end

  // Capture the stage-1 sum; the valid flag marks the fold cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q <= 32'd0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= start_i;
      if (start_i) begin
        sum_q <= sum_d;
      end
    end
  end

  // Stage 2 is combinational from sum_q; the caller registers it on csum_vld_o.
  assign csum_vld_o = vld_q;
  assign csum_o     = csum_fold(sum_q);

endmodule

// File: rtl/udp_tx_framer.sv
// Builds Ethernet II + IPv4 + UDP frames from a header descriptor and byte payload stream.
// Latency: first header byte valid on the third clock edge after the header handshake.
// Backpressure: registered output advances only when empty or accepted; payload tready follows it.
module udp_tx_framer
  import udp_tx_pkg::*;
#(
  parameter logic [7:0] IP_TTL_DEFAULT = 8'd64,
  parameter logic       IP_DF          = 1'b1
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic        s_udp_hdr_valid,
  output logic        s_udp_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [5:0]  s_ip_dscp,
  input  logic [1:0]  s_ip_ecn,
  input  logic [15:0] s_ip_identification,
  input  logic [7:0]  s_ip_ttl,
  input  logic [31:0] s_ip_source_ip,
  input  logic [31:0] s_ip_dest_ip,
  input  logic [15:0] s_udp_source_port,
  input  logic [15:0] s_udp_dest_port,
  input  logic [15:0] s_udp_length,
  input  logic [7:0]  s_udp_payload_axis_tdata,
  input  logic        s_udp_payload_axis_tvalid,
  output logic        s_udp_payload_axis_tready,
  input  logic        s_udp_payload_axis_tlast,
  input  logic        s_udp_payload_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic        error_payload_early_termination,
  output logic        error_payload_overrun,
  output logic        error_bad_length
);

  state_t      state_q, state_d;
  udp_tx_hdr_t hdr_q;
  logic [5:0]  byte_cnt_q;
  logic [15:0] pay_cnt_q;
  logic        bad_q;
  logic [15:0] ip_csum_q;

  logic        csum_vld;
  logic [15:0] csum_val;
  logic        csum_start;

  logic        out_free, hdr_acc, pay_acc, len_bad;
  logic        hdr_last_byte, pay_last_cnt;
  logic [15:0] ip_len;
  logic [335:0] hdr_vec;
  logic [7:0]  hdr_byte;

  logic        out_load, out_last_d, out_user_d;
  logic [7:0]  out_dat_d;
  logic        err_early_d, err_over_d, err_len_d;

  logic [7:0]  m_tdata_q;
  logic        m_tvalid_q, m_tlast_q, m_tuser_q;
  logic        err_early_q, err_over_q, err_len_q;

  assign out_free      = !m_tvalid_q || m_axis_tready;
  assign hdr_acc       = s_udp_hdr_valid && s_udp_hdr_ready;
  assign pay_acc       = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
  assign len_bad       = s_udp_length < 16'(UDP_HDR_BYTES);
  assign hdr_last_byte = byte_cnt_q == 6'(HDR_BYTES - 1);
  assign pay_last_cnt  = pay_cnt_q == 16'd1;
  assign csum_start    = (state_q == CSUM) && !csum_vld;

  // Whole 42-byte header as one MSB-first vector; byte n sits at bits [335-8n -: 8].
  assign ip_len  = hdr_q.udp_len + 16'd20;
  assign hdr_vec = {hdr_q.dest_mac, hdr_q.src_mac, ETHERTYPE_IPV4,
                    IP_VER_IHL, hdr_q.dscp, hdr_q.ecn, ip_len, hdr_q.ident,
                    1'b0, IP_DF, 14'b0, hdr_q.ttl, IP_PROTO_UDP, ip_csum_q,
                    hdr_q.src_ip, hdr_q.dst_ip,
                    hdr_q.src_port, hdr_q.dst_port, hdr_q.udp_len, 16'h0000};
  assign hdr_byte = hdr_vec[9'd335 - {byte_cnt_q, 3'b000} -: 8];

  ip_hdr_csum #(
    .IP_DF (IP_DF)
  ) u_csum (
    .clk_i      (logic_clk),
    .rst_ni     (logic_rst_n),
    .start_i    (csum_start),
    .dscp_ecn_i ({hdr_q.dscp, hdr_q.ecn}),
    .ident_i    (hdr_q.ident),
    .ttl_i      (hdr_q.ttl),
    .udp_len_i  (hdr_q.udp_len),
    .src_ip_i   (hdr_q.src_ip),
    .dst_ip_i   (hdr_q.dst_ip),
    .csum_vld_o (csum_vld),
    .csum_o     (csum_val)
  );

  // State register.
  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (hdr_acc) begin
          state_d = len_bad ? DROP : CSUM;
        end
      end
      CSUM: begin
        if (csum_vld) begin
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (out_free && hdr_last_byte) begin
          state_d = (pay_cnt_q == 16'd0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pay_acc) begin
          if (s_udp_payload_axis_tlast) begin
            state_d = IDLE;
          end else if (pay_last_cnt) begin
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (pay_acc && s_udp_payload_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshakes, next output byte and error strobes.
  always_comb begin
    s_udp_hdr_ready           = (state_q == IDLE) && logic_rst_n;
    s_udp_payload_axis_tready = 1'b0;
    out_load                  = 1'b0;
    out_dat_d                 = hdr_byte;
    out_last_d                = 1'b0;
    out_user_d                = 1'b0;
    err_early_d               = 1'b0;
    err_over_d                = 1'b0;
    err_len_d                 = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_len_d = hdr_acc && len_bad;
      end
      HEADER: begin
        out_load   = out_free;
        out_last_d = hdr_last_byte && (pay_cnt_q == 16'd0);
      end
      PAYLOAD: begin
        s_udp_payload_axis_tready = out_free;
        out_load                  = pay_acc;
        out_dat_d                 = s_udp_payload_axis_tdata;
        if (s_udp_payload_axis_tlast || pay_last_cnt) begin
          out_last_d = 1'b1;
          // Only a length-consistent end keeps the accumulated frame-bad flag.
          out_user_d = (s_udp_payload_axis_tlast && pay_last_cnt)
                     ? (bad_q || s_udp_payload_axis_tuser) : 1'b1;
        end
        err_early_d = pay_acc && s_udp_payload_axis_tlast && !pay_last_cnt;
        err_over_d  = pay_acc && !s_udp_payload_axis_tlast && pay_last_cnt;
      end
      DROP: begin
        s_udp_payload_axis_tready = 1'b1;
      end
      default: ;
    endcase
  end

  // Descriptor, counters, checksum and error strobes.
  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      hdr_q       <= '0;
      byte_cnt_q  <= 6'd0;
      pay_cnt_q   <= 16'd0;
      bad_q       <= 1'b0;
      ip_csum_q   <= 16'd0;
      err_early_q <= 1'b0;
      err_over_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      err_early_q <= err_early_d;
      err_over_q  <= err_over_d;
      err_len_q   <= err_len_d;
      if (hdr_acc) begin
        hdr_q.dest_mac <= s_eth_dest_mac;
        hdr_q.src_mac  <= s_eth_src_mac;
        hdr_q.dscp     <= s_ip_dscp;
        hdr_q.ecn      <= s_ip_ecn;
        hdr_q.ident    <= s_ip_identification;
        hdr_q.ttl      <= (s_ip_ttl == 8'd0) ? IP_TTL_DEFAULT : s_ip_ttl;
        hdr_q.src_ip   <= s_ip_source_ip;
        hdr_q.dst_ip   <= s_ip_dest_ip;
        hdr_q.src_port <= s_udp_source_port;
        hdr_q.dst_port <= s_udp_dest_port;
        hdr_q.udp_len  <= s_udp_length;
        pay_cnt_q      <= s_udp_length - 16'(UDP_HDR_BYTES);
        bad_q          <= 1'b0;
        byte_cnt_q     <= 6'd0;
      end
      if ((state_q == CSUM) && csum_vld) begin
        ip_csum_q <= csum_val;
      end
      if ((state_q == HEADER) && out_free) begin
        byte_cnt_q <= byte_cnt_q + 6'd1;
      end
      if ((state_q == PAYLOAD) && pay_acc) begin
        pay_cnt_q <= pay_cnt_q - 16'd1;
        bad_q     <= bad_q || s_udp_payload_axis_tuser;
      end
    end
  end

  // Output register: loads only when empty or its current byte is taken.
  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= 8'd0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
    end else if (out_free) begin
      m_tvalid_q <= out_load;
      if (out_load) begin
        m_tdata_q <= out_dat_d;
        m_tlast_q <= out_last_d;
        m_tuser_q <= out_user_d;
      end
    end
  end

  assign m_axis_tdata                    = m_tdata_q;
  assign m_axis_tvalid                   = m_tvalid_q;
  assign m_axis_tlast                    = m_tlast_q;
  assign m_axis_tuser                    = m_tuser_q;
  assign busy                            = state_q != IDLE;
  assign error_payload_early_termination = err_early_q;
  assign error_payload_overrun           = err_over_q;
  assign error_bad_length                = err_len_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer with a frame-level reference model and per-byte scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Output backpressure is either always-ready or pseudo-random.
module tb_udp_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [47:0] f_dmac = '0, f_smac = '0;
  logic [5:0]  f_dscp = '0;
  logic [1:0]  f_ecn = '0;
  logic [15:0] f_id = '0, f_sp = '0, f_dp = '0, f_len = '0;
  logic [7:0]  f_ttl = '0;
  logic [31:0] f_sip = '0, f_dip = '0;
  logic [7:0]  p_tdata = '0;
  logic        p_tvalid = 1'b0, p_tlast = 1'b0, p_tuser = 1'b0;
  logic        p_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic        m_tready = 1'b1;
  logic        busy, e_early, e_over, e_len;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  udp_tx_framer dut (
    .logic_clk                       (clk),
    .logic_rst_n                     (rst_n),
    .s_udp_hdr_valid                 (hdr_valid),
    .s_udp_hdr_ready                 (hdr_ready),
    .s_eth_dest_mac                  (f_dmac),
    .s_eth_src_mac                   (f_smac),
    .s_ip_dscp                       (f_dscp),
    .s_ip_ecn                        (f_ecn),
    .s_ip_identification             (f_id),
    .s_ip_ttl                        (f_ttl),
    .s_ip_source_ip                  (f_sip),
    .s_ip_dest_ip                    (f_dip),
    .s_udp_source_port               (f_sp),
    .s_udp_dest_port                 (f_dp),
    .s_udp_length                    (f_len),
    .s_udp_payload_axis_tdata        (p_tdata),
    .s_udp_payload_axis_tvalid       (p_tvalid),
    .s_udp_payload_axis_tready       (p_tready),
    .s_udp_payload_axis_tlast        (p_tlast),
    .s_udp_payload_axis_tuser        (p_tuser),
    .m_axis_tdata                    (m_tdata),
    .m_axis_tvalid                   (m_tvalid),
    .m_axis_tready                   (m_tready),
    .m_axis_tlast                    (m_tlast),
    .m_axis_tuser                    (m_tuser),
    .busy                            (busy),
    .error_payload_early_termination (e_early),
    .error_payload_overrun           (e_over),
    .error_bad_length                (e_len)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0] exp_q[$];       // {tuser, tlast, tdata}
  logic [7:0] pay_d[$];
  logic       pay_u[$];
  int exp_early, exp_over, exp_bad, exp_nbytes;

  task automatic model_frame();
    logic [7:0]  hb [42];
    logic [31:0] s;
    logic [15:0] iplen, cs;
    int p, k, n;
    logic anyu, last, user;
    exp_early = 0; exp_over = 0; exp_bad = 0; exp_nbytes = 0;
    if (f_len < 16'd8) begin
      exp_bad = 1;
      return;
    end
    p = int'(f_len) - 8;
    k = pay_d.size();
    iplen = f_len + 16'd20;
    for (int i = 0; i < 6; i++) begin
      hb[i]     = f_dmac[47 - 8*i -: 8];
      hb[6 + i] = f_smac[47 - 8*i -: 8];
    end
    hb[12] = 8'h08; hb[13] = 8'h00; hb[14] = 8'h45; hb[15] = {f_dscp, f_ecn};
    hb[16] = iplen[15:8]; hb[17] = iplen[7:0];
    hb[18] = f_id[15:8];  hb[19] = f_id[7:0];
    hb[20] = 8'h40; hb[21] = 8'h00;
    hb[22] = (f_ttl == 8'd0) ? 8'd64 : f_ttl;
    hb[23] = 8'd17; hb[24] = 8'h00; hb[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      hb[26 + i] = f_sip[31 - 8*i -: 8];
      hb[30 + i] = f_dip[31 - 8*i -: 8];
    end
    hb[34] = f_sp[15:8]; hb[35] = f_sp[7:0];
    hb[36] = f_dp[15:8]; hb[37] = f_dp[7:0];
    hb[38] = f_len[15:8]; hb[39] = f_len[7:0];
    hb[40] = 8'h00; hb[41] = 8'h00;
    s = 32'd0;
    for (int i = 0; i < 10; i++) s = s + {16'd0, hb[14 + 2*i], hb[15 + 2*i]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    hb[24] = cs[15:8]; hb[25] = cs[7:0];
    for (int i = 0; i < 42; i++) begin
      last = (i == 41) && (p == 0);
      exp_q.push_back({1'b0, last, hb[i]});
    end
    n = (k < p) ? k : p;
    anyu = 1'b0;
    for (int j = 0; j < n; j++) begin
      anyu = anyu | pay_u[j];
      last = (j == n - 1);
      user = last ? ((k == p) ? anyu : 1'b1) : 1'b0;
      exp_q.push_back({user, last, pay_d[j]});
    end
    exp_early = (k < p) ? 1 : 0;
    exp_over  = (k > p) ? 1 : 0;
    exp_nbytes = 42 + n;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       mon_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [10:0] prev_vec = '0;
  logic [7:0] cap [64];
  int cap_n = 0;
  int n_early = 0, n_over = 0, n_len = 0, n_prdy = 0;
  logic [9:0] mon_e;

  always @(negedge clk) begin
    if (e_early) n_early++;
    if (e_over)  n_over++;
    if (e_len)   n_len++;
    if (p_tready) n_prdy++;
    if (mon_en) begin
      if (prev_stall) chk("stall_hold", {53'd0, m_tvalid, m_tlast, m_tuser, m_tdata}, {53'd0, prev_vec});
      if (m_tvalid && m_tready) begin
        if (cap_n < 64) cap[cap_n] = m_tdata;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_byte: got %02h with no byte expected", m_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("frame_byte%0d", cap_n), {54'd0, m_tuser, m_tlast, m_tdata}, {54'd0, mon_e});
        end
        cap_n++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_vec   = {m_tvalid, m_tlast, m_tuser, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Output backpressure generator.
  logic rand_rdy = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_hdr();
    int t = 0;
    @(posedge clk); #1;
    hdr_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (hdr_ready) break;
      t++;
      if (t > 200) begin
        tests++; fails++;
        $display("FAIL hdr_handshake: got no ready in 200 cycles, expected ready");
        break;
      end
    end
    @(posedge clk); #1;
    hdr_valid = 1'b0;
  endtask

  task automatic send_payload();
    int t;
    for (int i = 0; i < pay_d.size(); i++) begin
      p_tdata = pay_d[i]; p_tuser = pay_u[i];
      p_tlast = (i == pay_d.size() - 1); p_tvalid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (p_tready) break;
        t++;
        if (t > 2000) break;
      end
      if (t > 2000) begin
        tests++; fails++;
        $display("FAIL payload_handshake: got no tready for byte %0d, expected tready", i);
        break;
      end
      @(posedge clk); #1;
    end
    p_tvalid = 1'b0; p_tlast = 1'b0; p_tuser = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic base_fields();
    f_dmac = 48'hffff_ffff_ffff; f_smac = 48'h0200_0000_0001;
    f_sip = 32'hc0a8_010a; f_dip = 32'hc0a8_0101;
    f_sp = 16'd1234; f_dp = 16'd5678; f_id = 16'd0; f_ttl = 8'd64;
    f_dscp = 6'd0; f_ecn = 2'd0;
  endtask

  task automatic set_pay(input int n);
    pay_d.delete(); pay_u.delete();
    for (int i = 0; i < n; i++) begin
      pay_d.push_back(8'(8'hA0 + i));
      pay_u.push_back(1'b0);
    end
  endtask

  task automatic run_frame(input string name, input bit measure_lat);
    int e;
    n_early = 0; n_over = 0; n_len = 0; n_prdy = 0; cap_n = 0;
    model_frame();
    send_hdr();
    @(negedge clk);
    chk({name, "_busy"}, 64'(busy), 64'd1);
    if (measure_lat) begin
      e = 0;
      while (!m_tvalid && e < 10) begin @(posedge clk); e++; @(negedge clk); end
      chk({name, "_first_byte_edge"}, 64'(e), 64'd3);
    end
    send_payload();
    wait_drain();
    chk({name, "_nbytes"}, 64'(cap_n), 64'(exp_nbytes));
    chk({name, "_early_pulses"}, 64'(n_early), 64'(exp_early));
    chk({name, "_overrun_pulses"}, 64'(n_over), 64'(exp_over));
    chk({name, "_badlen_pulses"}, 64'(n_len), 64'(exp_bad));
    chk({name, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  logic [7:0] t1_cap [46];

  initial begin
    int d, t;
    base_fields();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {53'd0, m_tvalid, m_tdata, m_tlast, m_tuser, busy, hdr_ready, p_tready,
                          e_early, e_over, e_len}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_hdr_ready", 64'(hdr_ready), 64'd1);
    mon_en = 1'b1;

    // 1: 4-byte payload, always-ready sink
    f_len = 16'd12; set_pay(4);
    run_frame("t1", 1'b1);
    chk("t1_last_byte_cnt", 64'(cap_n), 64'd46);
    chk("t1_dmac0", 64'(cap[0]), 64'hff);
    chk("t1_smac0", 64'(cap[6]), 64'h02);
    chk("t1_iplen", 64'({cap[16], cap[17]}), 64'h0020);
    chk("t1_ip_csum", 64'({cap[24], cap[25]}), 64'hb771);
    chk("t1_udp_csum", 64'({cap[40], cap[41]}), 64'h0000);
    chk("t1_payload_last", 64'(cap[45]), 64'ha3);
    for (int i = 0; i < 46; i++) t1_cap[i] = cap[i];

    // 2: same frame (TTL 0 selects default 64) with random sink stalls
    f_ttl = 8'd0; rand_rdy = 1'b1;
    run_frame("t2", 1'b0);
    rand_rdy = 1'b0; f_ttl = 8'd64;
    d = 0;
    for (int i = 0; i < 46; i++) if (cap[i] !== t1_cap[i]) d++;
    chk("t2_same_bytes", 64'(d), 64'd0);

    // 3: header only
    f_len = 16'd8; set_pay(0);
    run_frame("t3", 1'b0);
    chk("t3_payload_tready_cycles", 64'(n_prdy), 64'd0);

    // 4: early termination on the 3rd of 8 payload bytes
    f_len = 16'd16; set_pay(3); f_id = 16'h1234; f_dscp = 6'd46; f_ecn = 2'd1;
    run_frame("t4", 1'b0);
    base_fields();

    // 5: overrun, 5 bytes for a 2-byte payload
    f_len = 16'd10; set_pay(5);
    run_frame("t5", 1'b0);

    // 6a: bad length, payload drained, nothing emitted
    f_len = 16'd4; set_pay(3);
    run_frame("t6", 1'b0);

    // 6b: reset while in HEADER
    f_len = 16'd12; set_pay(4); cap_n = 0;
    model_frame();
    send_hdr();
    t = 0;
    while (cap_n < 10 && t < 200) begin @(negedge clk); t++; end
    chk("t6b_reached_header", 64'(cap_n >= 10), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6b_reset_outputs", {53'd0, m_tvalid, m_tdata, m_tlast, m_tuser, busy, hdr_ready, p_tready,
                              e_early, e_over, e_len}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6b_hdr_ready_after", 64'(hdr_ready), 64'd1);
    mon_en = 1'b1;

    // 7: recovery frame with an errored payload byte
    f_len = 16'd12; set_pay(4); pay_u[1] = 1'b1;
    run_frame("t7", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
